// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Two-requester round-robin write port for a 32x32 register file,
//            with an optional post-reset sweep that zeroes registers 1..31.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        flagRF,
    output logic [4:0]  addressRD,
    output logic [31:0] data,
    output logic        init_done,
    output logic [15:0] wr_count
);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    localparam state_t C_RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : ARB;
    localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_sweep;
    logic        r_prio_a;      // 1: A wins the next contention

    logic        r_a_full;
    logic [4:0]  r_a_addr;
    logic [31:0] r_a_data;
    logic        r_b_full;
    logic [4:0]  r_b_addr;
    logic [31:0] r_b_data;

    logic        r_flag;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        r_init_done;
    logic [15:0] r_wr_count;

    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_a_ready;
    logic        w_b_ready;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= C_RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        case (r_state)
            INIT: begin
                if (r_sweep == 5'd31) begin
                    w_state_next = ARB;
                end
            end
            ARB: begin
                w_grant_a = r_a_full && (!r_b_full || r_prio_a);
                w_grant_b = r_b_full && !w_grant_a;
                w_a_ready = !r_a_full || w_grant_a;
                w_b_ready = !r_b_full || w_grant_b;
            end
            default: begin
                w_state_next = C_RESET_STATE;
            end
        endcase
    end

    assign w_sel_addr = w_grant_a ? r_a_addr : r_b_addr;
    assign w_sel_data = w_grant_a ? r_a_data : r_b_data;

    // Ready is forced low during reset so no transfer completes on a reset edge.
    assign a_ready = w_a_ready && !reset;
    assign b_ready = w_b_ready && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sweep     <= 5'd1;
            r_prio_a    <= 1'b1;
            r_a_full    <= 1'b0;
            r_a_addr    <= 5'd0;
            r_a_data    <= 32'd0;
            r_b_full    <= 1'b0;
            r_b_addr    <= 5'd0;
            r_b_data    <= 32'd0;
            r_flag      <= 1'b0;
            r_addr      <= 5'd0;
            r_data      <= 32'd0;
            r_init_done <= 1'b0;
            r_wr_count  <= 16'd0;
        end else begin
            case (r_state)
                INIT: begin
                    r_flag  <= 1'b1;
                    r_addr  <= r_sweep;
                    r_data  <= 32'd0;
                    r_sweep <= r_sweep + 5'd1;
                end
                ARB: begin
                    r_init_done <= 1'b1;
                    r_flag      <= 1'b0;
                    if (w_grant_a || w_grant_b) begin
                        r_prio_a <= w_grant_b;
                        // A grant to register 0 is consumed without a write.
                        if (w_sel_addr != 5'd0) begin
                            r_flag <= 1'b1;
                            r_addr <= w_sel_addr;
                            r_data <= w_sel_data;
                            if (r_wr_count != C_COUNT_MAX) begin
                                r_wr_count <= r_wr_count + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_flag <= 1'b0;
                end
            endcase

            if (a_valid && w_a_ready) begin
                r_a_full <= 1'b1;
                r_a_addr <= a_addr;
                r_a_data <= a_data;
            end else if (w_grant_a) begin
                r_a_full <= 1'b0;
            end

            if (b_valid && w_b_ready) begin
                r_b_full <= 1'b1;
                r_b_addr <= b_addr;
                r_b_data <= b_data;
            end else if (w_grant_b) begin
                r_b_full <= 1'b0;
            end
        end
    end

    assign flagRF    = r_flag;
    assign addressRD = r_addr;
    assign data      = r_data;
    assign init_done = r_init_done;
    assign wr_count  = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        flagRF;
    logic [4:0]  addressRD;
    logic [31:0] data;
    logic        init_done;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .flagRF    (flagRF),
        .addressRD (addressRD),
        .data      (data),
        .init_done (init_done),
        .wr_count  (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flag"},  32'(flagRF),    32'd0);
        chk({tag, "_addr"},  32'(addressRD), 32'd0);
        chk({tag, "_data"},  data,           32'd0);
        chk({tag, "_done"},  32'(init_done), 32'd0);
        chk({tag, "_count"}, 32'(wr_count),  32'd0);
        chk({tag, "_ardy"},  32'(a_ready),   32'd0);
        chk({tag, "_brdy"},  32'(b_ready),   32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        a_addr  = 5'd0;
        a_data  = 32'd0;
        b_valid = 1'b0;
        b_addr  = 5'd0;
        b_data  = 32'd0;
        @(negedge clock);
        tick();
        chk_reset_outputs("rst");

        // Clear sweep: 31 consecutive zero writes to 1..31
        reset = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("sweep_flag", 32'(flagRF),    32'd1);
            chk("sweep_addr", 32'(addressRD), 32'(i));
            chk("sweep_data", data,           32'd0);
            chk("sweep_done", 32'(init_done), 32'd0);
            if (i < 31) begin
                chk("sweep_ardy", 32'(a_ready), 32'd0);
                chk("sweep_brdy", 32'(b_ready), 32'd0);
            end
        end
        tick();
        chk("post_sweep_flag", 32'(flagRF),    32'd0);
        chk("post_sweep_done", 32'(init_done), 32'd1);
        chk("post_sweep_addr", 32'(addressRD), 32'd31);
        chk("post_sweep_cnt",  32'(wr_count),  32'd0);

        // Single uncontended write from A
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEADBEEF;
        chk("a1_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        chk("a1_flag_pre", 32'(flagRF), 32'd0);
        tick();
        chk("a1_flag", 32'(flagRF),    32'd1);
        chk("a1_addr", 32'(addressRD), 32'd5);
        chk("a1_data", data,           32'hDEADBEEF);
        chk("a1_cnt",  32'(wr_count),  32'd1);
        tick();
        chk("a1_idle_flag", 32'(flagRF),    32'd0);
        chk("a1_idle_addr", 32'(addressRD), 32'd5);
        chk("a1_idle_data", data,           32'hDEADBEEF);

        // B write to register 0 is consumed silently
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'h12345678;
        chk("b0_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        chk("b0_ready_granted", 32'(b_ready), 32'd1);
        tick();
        chk("b0_flag", 32'(flagRF),    32'd0);
        chk("b0_cnt",  32'(wr_count),  32'd1);
        chk("b0_addr", 32'(addressRD), 32'd5);
        chk("b0_data", data,           32'hDEADBEEF);
        chk("b0_ready_after", 32'(b_ready), 32'd1);

        // Same-address collision: A first, B second
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h2;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk("col1_flag", 32'(flagRF),    32'd1);
        chk("col1_addr", 32'(addressRD), 32'd7);
        chk("col1_data", data,           32'h1);
        chk("col1_cnt",  32'(wr_count),  32'd2);
        tick();
        chk("col2_flag", 32'(flagRF),    32'd1);
        chk("col2_addr", 32'(addressRD), 32'd7);
        chk("col2_data", data,           32'h2);
        chk("col2_cnt",  32'(wr_count),  32'd3);
        tick();
        chk("col_idle_flag", 32'(flagRF), 32'd0);

        // Continuous contention: grants alternate A, B, A, B
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAAAA0001;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBBBB0002;
        chk("rr_load_ardy", 32'(a_ready), 32'd1);
        chk("rr_load_brdy", 32'(b_ready), 32'd1);
        tick();
        chk("rr_load_flag", 32'(flagRF), 32'd0);
        for (int n = 1; n <= 6; n++) begin
            chk("rr_ardy", 32'(a_ready), (n % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_brdy", 32'(b_ready), (n % 2 == 1) ? 32'd0 : 32'd1);
            tick();
            chk("rr_flag", 32'(flagRF),    32'd1);
            chk("rr_addr", 32'(addressRD), (n % 2 == 1) ? 32'd10 : 32'd11);
            chk("rr_data", data,           (n % 2 == 1) ? 32'hAAAA0001 : 32'hBBBB0002);
            chk("rr_cnt",  32'(wr_count),  32'(3 + n));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk("drain1_addr", 32'(addressRD), 32'd10);
        chk("drain1_cnt",  32'(wr_count),  32'd10);
        tick();
        chk("drain2_addr", 32'(addressRD), 32'd11);
        chk("drain2_cnt",  32'(wr_count),  32'd11);
        tick();
        chk("drain_idle_flag", 32'(flagRF), 32'd0);

        // Reset mid-sweep at address 12, then restart from 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("resweep_addr", 32'(addressRD), 32'(i));
        end
        reset = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        reset = 1'b0;
        tick();
        chk("restart_flag", 32'(flagRF),    32'd1);
        chk("restart_addr", 32'(addressRD), 32'd1);
        for (int i = 2; i <= 31; i++) begin
            tick();
        end
        chk("restart_last_addr", 32'(addressRD), 32'd31);
        tick();
        chk("restart_done", 32'(init_done), 32'd1);

        // Saturation of the write counter
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        tick();
        for (int n = 0; n < 65535; n++) begin
            tick();
        end
        chk("sat_cnt", 32'(wr_count), 32'h0000FFFF);
        tick();
        chk("sat_flag",      32'(flagRF),   32'd1);
        chk("sat_cnt_after", 32'(wr_count), 32'h0000FFFF);
        a_valid = 1'b0;
        b_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1, meaning that after reset the block writes zero to registers 1..31 before serving requesters (1) or serves them immediately (0).
REQ-002 SHALL have port clock, input, 1, meaning the single clock, with all state updating on the rising edge.
REQ-003 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-004 SHALL have port a_valid, input, 1, meaning requester A (ALU writeback) presents a write.
REQ-005 SHALL have port a_addr, input, 5, meaning requester A's destination register.
REQ-006 SHALL have port a_data, input, 32, meaning requester A's write data.
REQ-007 SHALL have port a_ready, output, 1, meaning the block accepts requester A's write this cycle.
REQ-008 SHALL have ports b_valid, b_addr, b_data and b_ready, with the same directions and widths as requester A's ports, for requester B (memory load writeback).
REQ-009 SHALL have port flagRF, output, 1, meaning the register-file write enable.
REQ-010 SHALL have port addressRD, output, 5, meaning the register-file write address.
REQ-011 SHALL have port data, output, 32, meaning the register-file write data.
REQ-012 SHALL have port init_done, output, 1, meaning the clear sweep is complete and requesters are served.
REQ-013 SHALL have port wr_count, output, 16, meaning the number of requester writes issued to the register file.

Function
REQ-014 SHALL have a state machine with states INIT and ARB.
REQ-015 SHALL leave reset in INIT when CLEAR_ON_RESET=1, and in ARB with init_done=1 when CLEAR_ON_RESET=0.
REQ-016 SHALL, in INIT, step a 5-bit sweep counter from 1 to 31, one value per cycle.
REQ-017 SHALL, during the sweep, register flagRF=1, addressRD=counter and data=0 on each edge, giving exactly 31 consecutive writes.
REQ-018 SHALL, after the edge that issues address 31, move to ARB, set init_done=1 and clear flagRF on the following edge unless a grant occurs.
REQ-019 SHALL hold a_ready=0 and b_ready=0 throughout INIT.
REQ-020 SHALL keep one holding slot per requester: valid bit, 5-bit address and 32-bit data.
REQ-021 SHALL complete a requester transfer at an edge where x_valid=1 and x_ready=1, loading that requester's slot.
REQ-022 SHALL drive x_ready=1 in ARB when that slot is empty or is granted this cycle, allowing one transfer per requester per cycle.
REQ-023 SHALL, in ARB, grant one occupied slot per cycle using round-robin: with both slots occupied, grant the slot not granted last; with one occupied, grant it.
REQ-024 SHALL initialise the round-robin pointer so that A wins the first contention after reset.
REQ-025 SHALL, on the edge where a slot is granted with address not 0, register flagRF=1, addressRD=slot address and data=slot data, clear the slot and increment wr_count.
REQ-026 SHALL have write latency of exactly one edge from transfer to flagRF when uncontended, and two edges when the request loses arbitration.
REQ-027 SHALL, for a granted slot with address 0, clear the slot and consume the grant cycle while leaving flagRF=0 and wr_count unchanged.
REQ-028 SHALL, on an ARB edge with no grant, register flagRF=0 and hold addressRD and data.
REQ-029 SHALL, when both slots target the same address, issue both writes in grant order so the later-granted data remains in the register file.
REQ-030 SHALL saturate wr_count at 16'hFFFF.
REQ-031 SHALL register all of flagRF, addressRD, data, init_done and wr_count, and SHALL never assert flagRF more than once per cycle.

Reset
REQ-032 SHALL, on any edge with reset=1, set flagRF=0, addressRD=0, data=0, init_done=0, wr_count=0, both slots empty, the sweep counter to 1 and the pointer to favour A.
REQ-033 SHALL drive a_ready=0 and b_ready=0 while reset=1.
REQ-034 SHALL, when reset is asserted mid-sweep or mid-arbitration, discard pending slots and restart the sweep from address 1 after reset deasserts.

Verification
REQ-035 SHALL be covered by a bench checking that, with CLEAR_ON_RESET=1 and reset released, flagRF=1 for 31 consecutive cycles with addressRD 1..31 and data=0, then init_done=1.
REQ-036 SHALL be covered by a bench checking that a_valid with a_addr=5 and a_data=32'hDEADBEEF gives flagRF=1, addressRD=5 and data=32'hDEADBEEF one edge later, and wr_count=1.
REQ-037 SHALL be covered by a bench checking that, with both requesters valid every cycle, grants alternate A,B,A,B, each requester's ready follows its grant pattern, and wr_count rises by 1 per cycle.
REQ-038 SHALL be covered by a bench checking that simultaneous writes A(addr 7, 32'h1) and B(addr 7, 32'h2) on a fresh pointer issue 32'h1 then 32'h2.
REQ-039 SHALL be covered by a bench checking that b_addr=0 is accepted, b_ready returns high, flagRF stays 0 and wr_count is unchanged.
REQ-040 SHALL be covered by a bench checking that reset asserted at sweep address 12 clears all outputs and restarts the sweep at address 1, and that wr_count held at 16'hFFFF stays saturated after a further write.
